test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/seq_pkg.sv | 14 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/test_sequencer.sv | 113 +++++++++++
 tb/tb_test_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared state encoding and default timing constants for the test sequencer.
package seq_pkg;

    localparam int unsigned COUNT_W = 8;
    localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd50000;
    localparam logic [31:0] TIMEOUT_CYCLES_DEF  = 32'd5000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SHOW = 2'd2
    } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for the start push-button.
// After reset the button must be seen released before any press is accepted.
module btn_debounce
    import seq_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic level
);

    logic [1:0]  sync_q;
    logic [1:0]  fill_q;
    logic [15:0] cnt_q;
    logic        armed_q;
    logic        last_c;

    assign last_c = (cnt_q == DEBOUNCE_CYCLES - 16'd1);

    // fill_q masks the reset-valued synchroniser output so it is never mistaken for a release
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q  <= 2'b00;
            fill_q  <= 2'b00;
            cnt_q   <= 16'd0;
            armed_q <= 1'b0;
            level   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            fill_q <= {fill_q[0], 1'b1};
            if (!fill_q[1]) begin
                cnt_q <= 16'd0;
            end else if (!armed_q) begin
                if (sync_q[1]) begin
                    cnt_q <= 16'd0;
                end else if (last_c) begin
                    armed_q <= 1'b1;
                    cnt_q   <= 16'd0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end else if (sync_q[1] == level) begin
                cnt_q <= 16'd0;
            end else if (last_c) begin
                level <= sync_q[1];
                cnt_q <= 16'd0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/test_sequencer.sv
// Push-button driven test sequencer: IDLE -> RUN -> SHOW with latched verdict LEDs.
// Optional RUN timeout is enabled by defining SEQ_TIMEOUT_EN.
module test_sequencer
    import seq_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [31:0] TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start_btn,
    input  logic               Done,
    input  logic               RSLT,
    output logic               Run,
    output logic               DISP_RSLT,
    output logic               Busy,
    output logic               Pass_LED,
    output logic               Fail_LED,
    output logic               Timeout_LED,
    output logic [COUNT_W-1:0] Test_count
);

    seq_state_e state_q;
    logic       level;
    logic       level_q;
    logic       start_req_c;
    logic       timeout_hit_c;
    logic       finish_c;
    logic       verdict_pass_c;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .Clk  (Clk),
        .Reset(Reset),
        .raw  (Start_btn),
        .level(level)
    );

    assign start_req_c = level & ~level_q;

`ifdef SEQ_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    assign timeout_hit_c = (to_cnt_q == TIMEOUT_CYCLES - 32'd1);

    // Timeout counter restarts on every entry into RUN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            to_cnt_q    <= 32'd0;
            Timeout_LED <= 1'b0;
        end else if (state_q != RUN && start_req_c) begin
            to_cnt_q    <= 32'd0;
            Timeout_LED <= 1'b0;
        end else if (state_q == RUN) begin
            if (finish_c) begin
                Timeout_LED <= ~Done;
            end else begin
                to_cnt_q <= to_cnt_q + 32'd1;
            end
        end
    end
`else
    assign timeout_hit_c = 1'b0;
    // No timeout hardware: the LED is a constant low
    assign Timeout_LED   = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

    // Done wins over a coincident timeout
    assign finish_c       = (state_q == RUN) && (Done || timeout_hit_c);
    assign verdict_pass_c = Done & RSLT;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            level_q    <= 1'b0;
            Run        <= 1'b0;
            DISP_RSLT  <= 1'b0;
            Busy       <= 1'b0;
            Pass_LED   <= 1'b0;
            Fail_LED   <= 1'b0;
            Test_count <= COUNT_W'(0);
        end else begin
            level_q <= level;
            case (state_q)
                IDLE, SHOW: begin
                    if (start_req_c) begin
                        state_q   <= RUN;
                        Run       <= 1'b1;
                        Busy      <= 1'b1;
                        DISP_RSLT <= 1'b0;
                        Pass_LED  <= 1'b0;
                        Fail_LED  <= 1'b0;
                    end
                end
                RUN: begin
                    if (finish_c) begin
                        state_q    <= SHOW;
                        Run        <= 1'b0;
                        Busy       <= 1'b0;
                        DISP_RSLT  <= 1'b1;
                        Pass_LED   <= verdict_pass_c;
                        Fail_LED   <= ~verdict_pass_c;
                        Test_count <= (Test_count == {COUNT_W{1'b1}}) ?
                                      Test_count : Test_count + COUNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_test_sequencer;

    typedef struct packed {
        logic       pass;
        logic       fail;
        logic       tmo;
        logic [7:0] count;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start_btn;
    logic       Done;
    logic       RSLT;
    logic       Run;
    logic       DISP_RSLT;
    logic       Busy;
    logic       Pass_LED;
    logic       Fail_LED;
    logic       Timeout_LED;
    logic [7:0] Test_count;

    int         checks    = 0;
    int         failures  = 0;
    int         run_rises = 0;
    int         exp_rises = 0;
    logic [7:0] exp_count = 8'd0;
    logic       run_q     = 1'b0;
    logic       disp_q    = 1'b0;
    exp_t       exp_q[$];

    test_sequencer #(
        .DEBOUNCE_CYCLES(16'd4),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start_btn  (Start_btn),
        .Done       (Done),
        .RSLT       (RSLT),
        .Run        (Run),
        .DISP_RSLT  (DISP_RSLT),
        .Busy       (Busy),
        .Pass_LED   (Pass_LED),
        .Fail_LED   (Fail_LED),
        .Timeout_LED(Timeout_LED),
        .Test_count (Test_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_run(input string name);
        logic seen;
        seen = 1'b0;
        exp_rises++;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (Run) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic push_verdict(input logic pass, input logic fail, input logic tmo);
        exp_t e;
        exp_count = (exp_count == 8'hFF) ? 8'hFF : exp_count + 8'd1;
        e.pass  = pass;
        e.fail  = fail;
        e.tmo   = tmo;
        e.count = exp_count;
        exp_q.push_back(e);
    endtask

    // Monitor: every entry into SHOW must match the oldest expected verdict
    always @(negedge Clk) begin
        exp_t e;
        if (Run && !run_q) run_rises++;
        if (DISP_RSLT && !disp_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_show actual=count %0h expected=no verdict", Test_count);
            end else begin
                e = exp_q.pop_front();
                check("show_pass_led", 32'(Pass_LED), 32'(e.pass));
                check("show_fail_led", 32'(Fail_LED), 32'(e.fail));
                check("show_timeout_led", 32'(Timeout_LED), 32'(e.tmo));
                check("show_test_count", 32'(Test_count), 32'(e.count));
                check("show_run_low", 32'(Run), 32'd0);
            end
        end
        run_q  = Run;
        disp_q = DISP_RSLT;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Start_btn = 1'b0; Done = 1'b0; RSLT = 1'b0;
        tick(2);
        check("rst_run", 32'(Run), 32'd0);
        check("rst_disp", 32'(DISP_RSLT), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_leds", {29'd0, Pass_LED, Fail_LED, Timeout_LED}, 32'd0);
        check("rst_count", 32'(Test_count), 32'd0);
        Reset = 1'b0;
        tick(10);

        // Done in IDLE is ignored
        Done = 1'b1; RSLT = 1'b1;
        tick(1);
        Done = 1'b0; RSLT = 1'b0;
        tick(1);
        check("idle_done_run", 32'(Run), 32'd0);
        check("idle_done_count", 32'(Test_count), 32'd0);

        // Three-cycle blip is filtered out
        Start_btn = 1'b1;
        tick(3);
        Start_btn = 1'b0;
        tick(15);
        check("short_press_run", 32'(Run), 32'd0);
        check("short_press_rises", 32'(run_rises), 32'(exp_rises));

        // Held press: single start, pass after 5 RUN cycles
        Start_btn = 1'b1;
        wait_run("run1_start");
        check("run1_busy", 32'(Busy), 32'd1);
        check("run1_leds_clear", {30'd0, Pass_LED, Fail_LED}, 32'd0);
        tick(4);
        Done = 1'b1; RSLT = 1'b1;
        push_verdict(1'b1, 1'b0, 1'b0);
        tick(1);
        Done = 1'b0; RSLT = 1'b0;
        check("run1_show_run", 32'(Run), 32'd0);
        check("run1_show_disp", 32'(DISP_RSLT), 32'd1);
        check("run1_count", 32'(Test_count), 32'(exp_count));
        tick(8);
        Start_btn = 1'b0;
        check("held_single_rise", 32'(run_rises), 32'(exp_rises));
        tick(10);

`ifdef SEQ_TIMEOUT_EN
        // No Done: timeout after 16 RUN cycles
        Start_btn = 1'b1;
        wait_run("run_to_start");
        Start_btn = 1'b0;
        push_verdict(1'b0, 1'b1, 1'b1);
        tick(15);
        check("to_cycle16_run", 32'(Run), 32'd1);
        tick(1);
        check("to_show_run", 32'(Run), 32'd0);
        check("to_show_disp", 32'(DISP_RSLT), 32'd1);
        tick(10);
        // Done on the timeout cycle wins
        Start_btn = 1'b1;
        wait_run("run_late_start");
        Start_btn = 1'b0;
        check("late_to_led_clear", 32'(Timeout_LED), 32'd0);
        tick(15);
        Done = 1'b1; RSLT = 1'b1;
        push_verdict(1'b1, 1'b0, 1'b0);
        tick(1);
        Done = 1'b0; RSLT = 1'b0;
        check("late_done_run", 32'(Run), 32'd0);
        check("late_done_tmo", 32'(Timeout_LED), 32'd0);
        tick(10);
`else
        // Without timeout, RUN waits on Done indefinitely
        Start_btn = 1'b1;
        wait_run("run_nto_start");
        Start_btn = 1'b0;
        tick(30);
        check("nto_run", 32'(Run), 32'd1);
        check("nto_busy", 32'(Busy), 32'd1);
        check("nto_led", 32'(Timeout_LED), 32'd0);
        Done = 1'b1; RSLT = 1'b1;
        push_verdict(1'b1, 1'b0, 1'b0);
        tick(1);
        Done = 1'b0; RSLT = 1'b0;
        check("nto_done_run", 32'(Run), 32'd0);
        tick(10);
`endif

        // Done in SHOW is ignored
        Done = 1'b1; RSLT = 1'b0;
        tick(1);
        Done = 1'b0;
        tick(1);
        check("show_done_pass", 32'(Pass_LED), 32'd1);
        check("show_done_count", 32'(Test_count), 32'(exp_count));
        check("show_done_disp", 32'(DISP_RSLT), 32'd1);

        // Restart from SHOW, second press in RUN ignored, then fail verdict
        Start_btn = 1'b1;
        wait_run("run_restart");
        check("restart_leds_clear", {29'd0, Pass_LED, Fail_LED, Timeout_LED}, 32'd0);
        check("restart_disp", 32'(DISP_RSLT), 32'd0);
        Start_btn = 1'b0;
        tick(6);
        Start_btn = 1'b1;
        tick(8);
        check("second_press_run", 32'(Run), 32'd1);
        check("second_press_rises", 32'(run_rises), 32'(exp_rises));
        Done = 1'b1; RSLT = 1'b0;
        push_verdict(1'b0, 1'b1, 1'b0);
        tick(1);
        Done = 1'b0;
        check("fail_show_run", 32'(Run), 32'd0);
        check("fail_count", 32'(Test_count), 32'(exp_count));
        Start_btn = 1'b0;
        tick(10);

        // Reset during RUN with the button held through release
        Start_btn = 1'b1;
        wait_run("run_pre_reset");
        tick(2);
        Reset = 1'b1;
        #1;
        exp_count = 8'd0;
        check("midrst_run", 32'(Run), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_disp", 32'(DISP_RSLT), 32'd0);
        check("midrst_leds", {29'd0, Pass_LED, Fail_LED, Timeout_LED}, 32'd0);
        check("midrst_count", 32'(Test_count), 32'd0);
        tick(2);
        Reset = 1'b0;
        tick(20);
        check("held_thru_reset_run", 32'(Run), 32'd0);
        check("held_thru_reset_rises", 32'(run_rises), 32'(exp_rises));
        Start_btn = 1'b0;
        tick(10);

        // Enough tests to saturate the counter
        for (int i = 0; i < 260; i++) begin
            Start_btn = 1'b1;
            wait_run("sat_run_start");
            Start_btn = 1'b0;
            tick(1);
            Done = 1'b1; RSLT = 1'(i % 2);
            push_verdict(1'(i % 2), ~1'(i % 2), 1'b0);
            tick(1);
            Done = 1'b0;
            tick(8);
        end
        check("sat_count", 32'(Test_count), 32'hFF);
        tick(5);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
